// File: rtl/store_byte_serializer_if.sv
// store_byte_serializer_if: store request and byte-wide memory write bus
interface store_byte_serializer_if #(parameter int ADDR_W = 32);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic              done;
  logic              misalign;
  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ack,
    input  st_ready, busy, mem_we, mem_addr, mem_wdata, done, misalign
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ack,
    output st_ready, busy, mem_we, mem_addr, mem_wdata, done, misalign
  );
endinterface

// File: rtl/store_byte_serializer.sv
// store_byte_serializer: splits an SB/SH/SW store into byte writes on an 8-bit memory port
module store_byte_serializer #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1
) (
  input logic clk,
  input logic rst,
  store_byte_serializer_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        last_q, idx, idx_n, sel;
  logic              done_q, done_n, mis_q, mis_n, load, illegal;
  assign illegal = (bus.st_size == 2'b11) ||
                   (bus.st_size == 2'b01 && bus.st_addr[0]) ||
                   (bus.st_size == 2'b10 && bus.st_addr[1:0] != 2'b00);
  always_comb begin
    state_n = state;
    idx_n   = idx;
    done_n  = 1'b0;
    mis_n   = 1'b0;
    load    = 1'b0;
    if (state == IDLE && bus.st_valid) begin
      mis_n   = illegal;
      load    = !illegal;
      state_n = illegal ? IDLE : WRITE;
      idx_n   = 2'd0;
    end else if (state == WRITE && bus.mem_ack) begin
      done_n  = (idx == last_q);
      state_n = (idx == last_q) ? IDLE : WRITE;
      idx_n   = (idx == last_q) ? idx : idx + 2'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 2'd0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      done_q <= done_n;
      mis_q  <= mis_n;
      if (load) begin
        addr_q <= bus.st_addr;
        data_q <= bus.st_data;
        last_q <= {bus.st_size[1], bus.st_size[1] | bus.st_size[0]};
      end
    end
  end
  // big-endian sends the most significant byte of the field first
  assign sel           = BIG_ENDIAN ? last_q - idx : idx;
  assign bus.st_ready  = (state == IDLE);
  assign bus.busy      = (state == WRITE);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = (state == WRITE) ? addr_q + {{(ADDR_W-2){1'b0}}, idx} : '0;
  assign bus.mem_wdata = (state == WRITE) ? data_q[{sel, 3'b000} +: 8] : 8'h00;
  assign bus.done      = done_q;
  assign bus.misalign  = mis_q;
endmodule

// File: tb/tb_store_byte_serializer.sv
// tb_store_byte_serializer: scoreboard bench for big- and little-endian serializers
module tb_store_byte_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_byte_serializer_if #(.ADDR_W(32)) b();
  store_byte_serializer_if #(.ADDR_W(32)) l();
  store_byte_serializer #(.ADDR_W(32), .BIG_ENDIAN(1)) dut_be (.clk(clk), .rst(rst), .bus(b));
  store_byte_serializer #(.ADDR_W(32), .BIG_ENDIAN(0)) dut_le (.clk(clk), .rst(rst), .bus(l));

  int n_tests = 0;
  int n_fail  = 0;
  int we_be   = 0;
  logic [39:0] sb_be[$];
  logic [39:0] sb_le[$];
  logic [39:0] e_be, e_le;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (b.mem_we) we_be++;
    if (b.done || b.misalign) check("be_done_mis_excl", 64'(b.done & b.misalign), 64'd0);
    if (b.mem_we && b.mem_ack) begin
      if (sb_be.size() == 0) check("be_unexpected_wr", 64'd1, 64'd0);
      else begin
        e_be = sb_be.pop_front();
        check("be_wr", 64'({b.mem_addr, b.mem_wdata}), 64'(e_be));
      end
    end
  end

  always @(negedge clk) begin
    if (l.mem_we && l.mem_ack) begin
      if (sb_le.size() == 0) check("le_unexpected_wr", 64'd1, 64'd0);
      else begin
        e_le = sb_le.pop_front();
        check("le_wr", 64'({l.mem_addr, l.mem_wdata}), 64'(e_le));
      end
    end
  end

  // Drives one store into the big-endian DUT; waits = ack-low cycles per byte
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz,
                       input int waits, input string tag);
    int nb, we0;
    logic ill;
    logic [39:0] exp;
    ill = sz == 2'b11 || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    nb  = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    if (!ill) for (int k = 0; k < nb; k++) sb_be.push_back({addr + 32'(k), data[8*(nb-1-k) +: 8]});
    we0 = we_be;
    b.st_valid = 1'b1; b.st_addr = addr; b.st_data = data; b.st_size = sz; b.mem_ack = 1'b1;
    @(posedge clk); #1;
    b.st_valid = 1'b0;
    if (ill) begin
      check({tag, "_mis"}, 64'(b.misalign), 64'd1);
      check({tag, "_ready"}, 64'(b.st_ready), 64'd1);
      check({tag, "_we"}, 64'(b.mem_we), 64'd0);
      @(posedge clk); #1;
      check({tag, "_mis_pulse"}, 64'(b.misalign), 64'd0);
      check({tag, "_we_after"}, 64'(we_be - we0), 64'd0);
      return;
    end
    for (int k = 0; k < nb; k++) begin
      exp = {addr + 32'(k), data[8*(nb-1-k) +: 8]};
      check({tag, "_we"}, 64'(b.mem_we), 64'd1);
      check({tag, "_busy"}, 64'(b.busy), 64'd1);
      check({tag, "_ready_lo"}, 64'(b.st_ready), 64'd0);
      for (int w = 0; w < waits; w++) begin
        b.mem_ack = 1'b0;
        @(posedge clk); #1;
        check({tag, "_hold"}, 64'({b.mem_addr, b.mem_wdata}), 64'(exp));
      end
      b.mem_ack = 1'b1;
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 64'(b.done), 64'd1);
    check({tag, "_ready"}, 64'(b.st_ready), 64'd1);
    check({tag, "_busy_lo"}, 64'(b.busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(b.done), 64'd0);
    check({tag, "_wr_cycles"}, 64'(we_be - we0), 64'(nb * (waits + 1)));
  endtask

  initial begin
    b.st_valid = 1'b0; b.st_addr = '0; b.st_data = '0; b.st_size = 2'b00; b.mem_ack = 1'b1;
    l.st_valid = 1'b0; l.st_addr = '0; l.st_data = '0; l.st_size = 2'b00; l.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 64'(b.mem_we), 64'd0);
    check("rst_addr", 64'(b.mem_addr), 64'd0);
    check("rst_wdata", 64'(b.mem_wdata), 64'd0);
    check("rst_done", 64'(b.done), 64'd0);
    check("rst_mis", 64'(b.misalign), 64'd0);
    check("rst_busy", 64'(b.busy), 64'd0);
    check("rst_ready", 64'(b.st_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    store(32'h100, 32'hDEADBEEF, 2'b10, 0, "sw");
    store(32'h202, 32'hFFFF1234, 2'b01, 0, "sh");
    store(32'h007, 32'h000000A5, 2'b00, 0, "sb");
    store(32'h102, 32'hCAFEF00D, 2'b10, 0, "mis_sw");
    store(32'h003, 32'h00001234, 2'b01, 0, "mis_sh");
    store(32'h000, 32'h12345678, 2'b11, 0, "mis_sz");
    store(32'h010, 32'h01020304, 2'b10, 3, "wait");

    // reset after the second ack of a word store: only two bytes may be written
    sb_be.push_back({32'h40, 8'h11});
    sb_be.push_back({32'h41, 8'h22});
    b.st_valid = 1'b1; b.st_addr = 32'h40; b.st_data = 32'h11223344; b.st_size = 2'b10; b.mem_ack = 1'b1;
    @(posedge clk); #1;
    b.st_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; b.mem_ack = 1'b0;
    @(posedge clk); #1;
    check("rstmid_we", 64'(b.mem_we), 64'd0);
    check("rstmid_ready", 64'(b.st_ready), 64'd1);
    check("rstmid_done", 64'(b.done), 64'd0);
    rst = 1'b0; b.mem_ack = 1'b1;
    @(posedge clk); #1;
    check("rstmid_done2", 64'(b.done), 64'd0);
    store(32'h020, 32'h00000055, 2'b00, 0, "rst_sb");

    // little-endian word, then a half-word held over the done cycle
    sb_le.push_back({32'h0, 8'hEF});
    sb_le.push_back({32'h1, 8'hBE});
    sb_le.push_back({32'h2, 8'hAD});
    sb_le.push_back({32'h3, 8'hDE});
    sb_le.push_back({32'h10, 8'hCD});
    sb_le.push_back({32'h11, 8'hAB});
    l.st_valid = 1'b1; l.st_addr = 32'h0; l.st_data = 32'hDEADBEEF; l.st_size = 2'b10;
    @(posedge clk); #1;
    l.st_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("le_we", 64'(l.mem_we), 64'd1);
      @(posedge clk); #1;
    end
    check("le_we4", 64'(l.mem_we), 64'd1);
    l.st_valid = 1'b1; l.st_addr = 32'h10; l.st_data = 32'h1234ABCD; l.st_size = 2'b01;
    @(posedge clk); #1;
    check("le_done", 64'(l.done), 64'd1);
    check("le_ready_done", 64'(l.st_ready), 64'd1);
    @(posedge clk); #1;
    l.st_valid = 1'b0;
    check("le_b2b_we", 64'(l.mem_we), 64'd1);
    check("le_b2b_ready", 64'(l.st_ready), 64'd0);
    @(posedge clk); #1;
    check("le_b2b_we2", 64'(l.mem_we), 64'd1);
    @(posedge clk); #1;
    check("le_b2b_done", 64'(l.done), 64'd1);
    @(posedge clk); #1;

    check("sb_be_empty", 64'(sb_be.size()), 64'd0);
    check("sb_le_empty", 64'(sb_le.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
